// File: rtl/bus_pkg.sv
// Shared definitions for the parallel-bus master engine: state encoding,
// slave-id width and the one-hot slave select helper.
package bus_pkg;

   localparam int unsigned BUS_MAX_SLAVES = 4;
   localparam int unsigned BUS_SLAVE_W    = $clog2(BUS_MAX_SLAVES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRITE     = 3'd1,
      READ_REQ  = 3'd2,
      READ_WAIT = 3'd3,
      RESP      = 3'd4
   } bus_mst_state_e;

   function automatic logic [BUS_MAX_SLAVES-1:0] onehot_sel(input logic [BUS_SLAVE_W-1:0] id);
      logic [BUS_MAX_SLAVES-1:0] sel;
      sel     = '0;
      sel[id] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/bus_master_ctrl.sv
// Command-driven bus master: turns valid/ready commands into one-hot
// selected bus transfers and returns exactly one response per command.
module bus_master_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = 3,
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned MAX_NO_OF_SLAVES = BUS_MAX_SLAVES,
   parameter int unsigned NO_OF_SLAVES     = 2,
   parameter int unsigned RD_LATENCY       = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic                                cmd_write,
   input  logic [$clog2(MAX_NO_OF_SLAVES)-1:0] cmd_slave,
   input  logic [ADDR_WIDTH-1:0]               cmd_addr,
   input  logic [DATA_WIDTH-1:0]               cmd_wdata,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic                                rsp_err,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic [ADDR_WIDTH-1:0]               addr,
   output logic                                rd,
   output logic                                wr,
   output logic [MAX_NO_OF_SLAVES-1:0]         en,
   output logic [DATA_WIDTH-1:0]               wdata,
   input  logic [DATA_WIDTH-1:0]               m_rdata
);

   localparam int unsigned CNT_W = 3;

   bus_mst_state_e              state, state_n;
   logic [CNT_W-1:0]            cnt, cnt_n;
   logic                        cmd_ready_n, rsp_valid_n, rsp_err_n;
   logic [DATA_WIDTH-1:0]       rsp_rdata_n, wdata_n;
   logic [ADDR_WIDTH-1:0]       addr_n;
   logic                        rd_n, wr_n;
   logic [MAX_NO_OF_SLAVES-1:0] en_n, sel_cmd;
   logic                        slave_bad;

   assign sel_cmd   = MAX_NO_OF_SLAVES'(onehot_sel(BUS_SLAVE_W'(cmd_slave)));
   assign slave_bad = 32'(cmd_slave) >= NO_OF_SLAVES;

   // Next-state and next-output logic; the bus registers double as the command latch.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cmd_ready_n = 1'b0;
      rsp_valid_n = rsp_valid;
      rsp_err_n   = rsp_err;
      rsp_rdata_n = rsp_rdata;
      addr_n      = '0;
      rd_n        = 1'b0;
      wr_n        = 1'b0;
      en_n        = '0;
      wdata_n     = '0;

      case (state)
         IDLE: begin
            cmd_ready_n = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_n = 1'b0;
               if (slave_bad) begin
                  state_n     = RESP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
               end else if (cmd_write) begin
                  state_n = WRITE;
                  wr_n    = 1'b1;
                  en_n    = sel_cmd;
                  addr_n  = cmd_addr;
                  wdata_n = cmd_wdata;
               end else begin
                  state_n = READ_REQ;
                  rd_n    = 1'b1;
                  en_n    = sel_cmd;
                  addr_n  = cmd_addr;
               end
            end
         end
         WRITE: begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
         end
         READ_REQ: begin
            state_n = READ_WAIT;
            en_n    = en;
            addr_n  = addr;
            cnt_n   = CNT_W'(RD_LATENCY);
         end
         READ_WAIT: begin
            // Keep the slave selected until its data is captured.
            en_n   = en;
            addr_n = addr;
            if (cnt == CNT_W'(1)) begin
               state_n     = RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = m_rdata;
               en_n        = '0;
               addr_n      = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n     = IDLE;
               cmd_ready_n = 1'b1;
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         addr      <= '0;
         rd        <= 1'b0;
         wr        <= 1'b0;
         en        <= '0;
         wdata     <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cmd_ready <= cmd_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_err   <= rsp_err_n;
         rsp_rdata <= rsp_rdata_n;
         addr      <= addr_n;
         rd        <= rd_n;
         wr        <= wr_n;
         en        <= en_n;
         wdata     <= wdata_n;
      end
   end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench for bus_master_ctrl: directed scenarios plus a random
// stream, with responses checked in order against a scoreboard queue.
module tb_bus_master_ctrl;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;
   localparam int unsigned MS = 4;
   localparam int unsigned NS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance with RD_LATENCY = 1
   logic          rst, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err, rd, wr;
   logic [1:0]    cmd_slave;
   logic [AW-1:0] cmd_addr, addr;
   logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, m_rdata;
   logic [MS-1:0] en;

   // Instance with RD_LATENCY = 3
   logic          rst3, cmd_valid3, cmd_ready3, cmd_write3, rsp_valid3, rsp_ready3, rsp_err3, rd3, wr3;
   logic [1:0]    cmd_slave3;
   logic [AW-1:0] cmd_addr3, addr3;
   logic [DW-1:0] cmd_wdata3, rsp_rdata3, wdata3, m_rdata3;
   logic [MS-1:0] en3;

   int            n_pass = 0;
   int            n_total = 0;
   logic [DW:0]   sb [$];
   logic [7:0]    shadow [2][8];
   bit            mon_on = 1'b0;

   bus_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_NO_OF_SLAVES(MS),
                     .NO_OF_SLAVES(NS), .RD_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_slave(cmd_slave), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .addr(addr), .rd(rd), .wr(wr),
      .en(en), .wdata(wdata), .m_rdata(m_rdata));

   bus_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_NO_OF_SLAVES(MS),
                     .NO_OF_SLAVES(NS), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_write(cmd_write3), .cmd_slave(cmd_slave3), .cmd_addr(cmd_addr3),
      .cmd_wdata(cmd_wdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_err(rsp_err3), .rsp_rdata(rsp_rdata3), .addr(addr3), .rd(rd3), .wr(wr3),
      .en(en3), .wdata(wdata3), .m_rdata(m_rdata3));

   function automatic logic [7:0] init_val(input int s, input int a);
      if (s == 0 && a == 3) return 8'h3C;
      return 8'(s * 16 + a * 7 + 17);
   endfunction

   // Slave models: data is valid on m_rdata only in cycle T+1+RD_LATENCY.
   logic [7:0] smem [2][8];
   logic [2:0] rcnt, raddr;
   logic       rsel;
   always @(posedge clk) begin
      if (rst) begin
         rcnt <= 3'd0;
         for (int s = 0; s < 2; s++)
            for (int a = 0; a < 8; a++) smem[s][a] <= init_val(s, a);
      end else begin
         if (wr && en[1]) smem[1][addr] <= wdata;
         else if (wr && en[0]) smem[0][addr] <= wdata;
         if (rd) begin
            rcnt  <= 3'd1;
            rsel  <= en[1];
            raddr <= addr;
         end else if (rcnt != 3'd0) rcnt <= rcnt - 3'd1;
      end
   end
   assign m_rdata = (rcnt == 3'd1) ? smem[rsel][raddr] : 8'hEE;

   logic [2:0] rcnt3, raddr3;
   logic       rsel3;
   always @(posedge clk) begin
      if (rst3) rcnt3 <= 3'd0;
      else if (rd3) begin
         rcnt3  <= 3'd3;
         rsel3  <= en3[1];
         raddr3 <= addr3;
      end else if (rcnt3 != 3'd0) rcnt3 <= rcnt3 - 3'd1;
   end
   assign m_rdata3 = (rcnt3 == 3'd1) ? init_val(int'(rsel3), int'(raddr3)) : 8'hEE;

   task automatic push_expected(input logic w, input logic [1:0] s, input logic [2:0] a,
                                input logic [7:0] d);
      if (s >= 2'd2) sb.push_back({1'b1, 8'h00});
      else if (w) begin
         shadow[s[0]][a] = d;
         sb.push_back({1'b0, 8'h00});
      end else sb.push_back({1'b0, shadow[s[0]][a]});
   endtask

   // Called at a negedge; returns at the negedge of the cycle after acceptance.
   task automatic issue(input logic w, input logic [1:0] s, input logic [2:0] a,
                        input logic [7:0] d);
      int guard = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_slave = s; cmd_addr = a; cmd_wdata = d;
      while (cmd_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_total++;
      if (guard >= 200) $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
      else n_pass++;
      push_expected(w, s, a, d);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Per-cycle bus invariants and in-order response scoreboard.
   task automatic monitor();
      logic [DW:0] exp;
      forever begin
         @(negedge clk);
         #2;
         if (mon_on) begin
            n_total++;
            if (((en & (en - 4'd1)) == 4'd0) && !(rd && wr) && (wr || wdata == 8'h00)
                && !(cmd_ready && rsp_valid)) n_pass++;
            else $display("FAIL bus_invariant: en=%b rd=%b wr=%b wdata=%h cmd_ready=%b rsp_valid=%b, required one-hot/zero en, exclusive strobes, idle wdata 0",
                          en, rd, wr, wdata, cmd_ready, rsp_valid);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
               n_total++;
               if (sb.size() == 0)
                  $display("FAIL rsp_order: unexpected response err=%b rdata=%h, required none", rsp_err, rsp_rdata);
               else begin
                  exp = sb.pop_front();
                  if ({rsp_err, rsp_rdata} !== exp)
                     $display("FAIL rsp_scoreboard: got err=%b rdata=%h, required err=%b rdata=%h",
                              rsp_err, rsp_rdata, exp[DW], exp[DW-1:0]);
                  else n_pass++;
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, addr, rd, wr, en, wdata} !== 28'd0)
         $display("FAIL reset_outputs: got %h, required all zero", {cmd_ready, rsp_valid, rsp_err, rsp_rdata, addr, rd, wr, en, wdata});
      else n_pass++;
      rst = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b1 || {rsp_valid, rd, wr, en} !== 7'd0)
         $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b en=%b, required 1,0,0", cmd_ready, rsp_valid, en);
      else n_pass++;
      mon_on = 1'b1;
   endtask

   task automatic test_write();
      issue(1'b1, 2'd1, 3'd5, 8'hA5);
      n_total++;
      if ({wr, rd, en, addr, wdata, cmd_ready} !== {1'b1, 1'b0, 4'b0010, 3'd5, 8'hA5, 1'b0})
         $display("FAIL write_strobe: wr=%b rd=%b en=%b addr=%0d wdata=%h, required 1,0,0010,5,a5", wr, rd, en, addr, wdata);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, wr, en} !== {1'b1, 1'b0, 8'h00, 1'b0, 4'd0})
         $display("FAIL write_resp: valid=%b err=%b rdata=%h wr=%b en=%b, required 1,0,00,0,0", rsp_valid, rsp_err, rsp_rdata, wr, en);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL write_ready: cmd_ready=%b rsp_valid=%b, required 1,0", cmd_ready, rsp_valid);
      else n_pass++;
   endtask

   task automatic test_read();
      issue(1'b0, 2'd0, 3'd3, 8'h00);
      n_total++;
      if ({rd, wr, en, addr} !== {1'b1, 1'b0, 4'b0001, 3'd3})
         $display("FAIL read_strobe: rd=%b wr=%b en=%b addr=%0d, required 1,0,0001,3", rd, wr, en, addr);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({rd, en, addr, rsp_valid} !== {1'b0, 4'b0001, 3'd3, 1'b0})
         $display("FAIL read_hold: rd=%b en=%b addr=%0d rsp_valid=%b, required 0,0001,3,0", rd, en, addr, rsp_valid);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, en} !== {1'b1, 1'b0, 8'h3C, 4'd0})
         $display("FAIL read_resp: valid=%b err=%b rdata=%h en=%b, required 1,0,3c,0", rsp_valid, rsp_err, rsp_rdata, en);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_error();
      issue(1'b1, 2'd3, 3'd1, 8'hFF);
      n_total++;
      if ({rsp_valid, rsp_err, rsp_rdata, rd, wr, en, addr, wdata} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00})
         $display("FAIL err_slave3: valid=%b err=%b rdata=%h rd=%b wr=%b en=%b, required 1,1,00,0,0,0", rsp_valid, rsp_err, rsp_rdata, rd, wr, en);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL err_ready: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
      issue(1'b0, 2'd2, 3'd4, 8'h00);
      n_total++;
      if ({rsp_valid, rsp_err, rd, wr, en} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0})
         $display("FAIL err_slave2: valid=%b err=%b rd=%b wr=%b en=%b, required 1,1,0,0,0", rsp_valid, rsp_err, rd, wr, en);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_stall();
      int bad = 0;
      rsp_ready = 1'b0;
      issue(1'b0, 2'd1, 3'd5, 8'h00);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || cmd_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      n_total++;
      if (bad != 0) $display("FAIL stall_hold: %0d unstable cycles (last valid=%b rdata=%h cmd_ready=%b), required 0", bad, rsp_valid, rsp_rdata, cmd_ready);
      else n_pass++;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL stall_release: cmd_ready=%b rsp_valid=%b, required 1,0", cmd_ready, rsp_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      int seen = 0;
      n_total++;
      if (cmd_ready3 !== 1'b1) $display("FAIL l3_idle: cmd_ready=%b, required 1", cmd_ready3);
      else n_pass++;
      cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_slave3 = 2'd0; cmd_addr3 = 3'd3; rsp_ready3 = 1'b1;
      @(negedge clk);
      cmd_valid3 = 1'b0;
      n_total++;
      if ({rd3, en3} !== {1'b1, 4'b0001}) $display("FAIL l3_rd: rd=%b en=%b, required 1,0001", rd3, en3);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({rd3, en3, addr3, rsp_valid3} !== {1'b0, 4'b0001, 3'd3, 1'b0})
         $display("FAIL l3_wait: rd=%b en=%b addr=%0d valid=%b, required 0,0001,3,0", rd3, en3, addr3, rsp_valid3);
      else n_pass++;
      rst3 = 1'b1;
      @(negedge clk);
      n_total++;
      if ({cmd_ready3, rsp_valid3, rsp_err3, rsp_rdata3, addr3, rd3, wr3, en3, wdata3} !== 28'd0)
         $display("FAIL l3_reset: got %h, required all zero", {cmd_ready3, rsp_valid3, rsp_err3, rsp_rdata3, addr3, rd3, wr3, en3, wdata3});
      else n_pass++;
      rst3 = 1'b0;
      @(negedge clk);
      n_total++;
      if (cmd_ready3 !== 1'b1) $display("FAIL l3_release: cmd_ready=%b, required 1", cmd_ready3);
      else n_pass++;
      repeat (8) begin
         if (rsp_valid3 !== 1'b0) seen++;
         @(negedge clk);
      end
      n_total++;
      if (seen != 0) $display("FAIL l3_dropped: %0d response cycles, required 0", seen);
      else n_pass++;
      cmd_valid3 = 1'b1; cmd_slave3 = 2'd1; cmd_addr3 = 3'd6;
      @(negedge clk);
      cmd_valid3 = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (rsp_valid3 !== 1'b0) $display("FAIL l3_early: rsp_valid=%b at T+4, required 0", rsp_valid3);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({rsp_valid3, rsp_err3, rsp_rdata3} !== {1'b1, 1'b0, init_val(1, 6)})
         $display("FAIL l3_read: valid=%b err=%b rdata=%h, required 1,0,%h", rsp_valid3, rsp_err3, rsp_rdata3, init_val(1, 6));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int guard = 0;
      bit acc = 1'b0;
      while ((sent < 20 || cmd_valid || sb.size() != 0) && guard < 3000) begin
         if (acc) begin
            cmd_valid = 1'b0;
            acc = 1'b0;
         end
         if (!cmd_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
            cmd_write = 1'($urandom_range(0, 1));
            cmd_slave = 2'($urandom_range(0, 1));
            cmd_addr  = 3'($urandom_range(0, 7));
            cmd_wdata = 8'($urandom_range(0, 200));
            cmd_valid = 1'b1;
            sent++;
         end
         rsp_ready = 1'($urandom_range(0, 1));
         if (cmd_valid && cmd_ready) begin
            push_expected(cmd_write, cmd_slave, cmd_addr, cmd_wdata);
            acc = 1'b1;
         end
         @(negedge clk);
         guard++;
      end
      rsp_ready = 1'b1;
      n_total++;
      if (guard >= 3000) $display("FAIL b2b_timeout: sent=%0d pending=%0d, required stream drained", sent, sb.size());
      else n_pass++;
   endtask

   task automatic test_drain();
      repeat (4) @(negedge clk);
      n_total++;
      if (sb.size() != 0) $display("FAIL drain: %0d responses missing, required 0", sb.size());
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = 2'd0; cmd_addr = 3'd0;
      cmd_wdata = 8'h00; rsp_ready = 1'b1;
      rst3 = 1'b1; cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_slave3 = 2'd0; cmd_addr3 = 3'd0;
      cmd_wdata3 = 8'h00; rsp_ready3 = 1'b1;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 8; a++) shadow[s][a] = init_val(s, a);
      fork
         monitor();
      join_none
      test_reset();
      test_write();
      test_read();
      test_error();
      test_stall();
      test_reset_mid_read();
      test_back_to_back();
      test_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
